// File: rtl/name_feeder_pkg.sv
// name_feeder_pkg: shared state enum, word/name types and default sizing for the name feeder
// Contents: state_t (IDLE/RUN/DONE), word_t, name_t, default WORD_SIZE/MAX_NAME_LENGTH, idx_bits helper.
package name_feeder_pkg;
  localparam int WORD_SIZE_DEF = 32;
  localparam int MAX_NAME_LENGTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [WORD_SIZE_DEF-1:0] word_t;
  typedef word_t [MAX_NAME_LENGTH_DEF-1:0] name_t;
  function automatic int idx_bits(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/name_feeder_if.sv
// name_feeder_if: table-write, run-control and name-output signals of the name feeder
// slave: DUT view (write port, cfg/start/stop, out_ready in; wr_err, out_* and done out).
// master: producer/consumer view. Stats ports exist only with NAME_FEEDER_STATS_EN.
interface name_feeder_if import name_feeder_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MAX_NAME_LENGTH = MAX_NAME_LENGTH_DEF,
  parameter int NUM_NAMES = 9
) ();
  localparam int NW = idx_bits(NUM_NAMES);
  localparam int WW = idx_bits(MAX_NAME_LENGTH);
  localparam int CW = $clog2(NUM_NAMES) + 1;
  logic wr_en;
  logic [NW-1:0] wr_name;
  logic [WW-1:0] wr_word;
  logic [WORD_SIZE-1:0] wr_data;
  logic wr_err;
  logic [CW-1:0] cfg_count;
  logic cfg_loop;
  logic start;
  logic stop;
  logic out_valid;
  logic out_ready;
  logic [WORD_SIZE*MAX_NAME_LENGTH-1:0] out_name;
  logic [NW-1:0] out_idx;
  logic done;
`ifdef NAME_FEEDER_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif
  modport slave (
    input wr_en, wr_name, wr_word, wr_data, cfg_count, cfg_loop, start, stop, out_ready,
    output wr_err, out_valid, out_name, out_idx, done
`ifdef NAME_FEEDER_STATS_EN
    , output stat_issued, stat_stall
`endif
  );
  modport master (
    output wr_en, wr_name, wr_word, wr_data, cfg_count, cfg_loop, start, stop, out_ready,
    input wr_err, out_valid, out_name, out_idx, done
`ifdef NAME_FEEDER_STATS_EN
    , input stat_issued, stat_stall
`endif
  );
endinterface

// File: rtl/name_feeder_table.sv
// name_table: name register file, one word write port and one combinational whole-name read port
// Ports: clk, we/wname/wword/wdata (word write), rname/rdata (name read). No reset: contents survive rst.
module name_table #(
  parameter int WORD_SIZE = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int NUM_NAMES = 9,
  parameter int NW = 4,
  parameter int WW = 3
) (
  input  logic clk,
  input  logic we,
  input  logic [NW-1:0] wname,
  input  logic [WW-1:0] wword,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [NW-1:0] rname,
  output logic [WORD_SIZE*MAX_NAME_LENGTH-1:0] rdata
);
  logic [MAX_NAME_LENGTH-1:0][WORD_SIZE-1:0] mem [NUM_NAMES];
  always_ff @(posedge clk)
    if (we) mem[wname][wword] <= wdata;
  assign rdata = mem[rname];
endmodule

// File: rtl/name_feeder.sv
// name_feeder: issues stored names in index order over a valid/ready handshake, one-shot or looping
// Ports: clk, rst (sync, active-high), bus (name_feeder_if.slave).
// Optional NAME_FEEDER_STATS_EN adds saturating stat_issued/stat_stall counters on the bus.
module name_feeder import name_feeder_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MAX_NAME_LENGTH = MAX_NAME_LENGTH_DEF,
  parameter int NUM_NAMES = 9
) (
  input logic clk,
  input logic rst,
  name_feeder_if.slave bus
);
  localparam int NW = idx_bits(NUM_NAMES);
  localparam int WW = idx_bits(MAX_NAME_LENGTH);
  localparam int CW = $clog2(NUM_NAMES) + 1;
  localparam int NL = WORD_SIZE * MAX_NAME_LENGTH;
  state_t state, state_n;
  logic [CW-1:0] count, count_n, clamp;
  logic loop, loop_n;
  logic [NW-1:0] idx, idx_n;
  logic [NL-1:0] rd_name;
  logic run, hs, go, last, wr_bad, we;
  assign run = state == RUN;
  assign hs = run && bus.out_ready;
  assign go = !run && bus.start;
  assign clamp = 32'(bus.cfg_count) > NUM_NAMES ? CW'(NUM_NAMES) : bus.cfg_count;
  assign last = CW'(idx) + CW'(1) == count;
  assign wr_bad = 32'(bus.wr_name) >= NUM_NAMES || 32'(bus.wr_word) >= MAX_NAME_LENGTH;
  assign we = bus.wr_en && !rst && !run && !wr_bad;
  name_table #(
    .WORD_SIZE(WORD_SIZE), .MAX_NAME_LENGTH(MAX_NAME_LENGTH), .NUM_NAMES(NUM_NAMES), .NW(NW), .WW(WW)
  ) u_table (
    .clk(clk), .we(we), .wname(bus.wr_name), .wword(bus.wr_word), .wdata(bus.wr_data),
    .rname(idx), .rdata(rd_name)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      loop <= 1'b0;
      idx <= '0;
      bus.wr_err <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      loop <= loop_n;
      idx <= idx_n;
      bus.wr_err <= bus.wr_en && (run || wr_bad);
    end
  end
  // A stop in the same cycle as a handshake still lets idx advance; only the state is overridden.
  always_comb begin
    state_n = state;
    count_n = count;
    loop_n = loop;
    idx_n = idx;
    if (go) begin
      count_n = clamp;
      loop_n = bus.cfg_loop;
      idx_n = '0;
      state_n = clamp == '0 ? DONE : RUN;
    end else if (run) begin
      if (hs) begin
        idx_n = last ? '0 : idx + NW'(1);
        state_n = last && !loop ? DONE : RUN;
      end
      if (bus.stop) state_n = IDLE;
    end
  end
  assign bus.out_valid = run;
  assign bus.out_name = run ? rd_name : '0;
  assign bus.out_idx = run ? idx : '0;
  assign bus.done = state == DONE;
`ifdef NAME_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || go) begin
      bus.stat_issued <= '0;
      bus.stat_stall <= '0;
    end else begin
      if (hs && ~&bus.stat_issued) bus.stat_issued <= bus.stat_issued + 32'd1;
      if (run && !bus.out_ready && ~&bus.stat_stall) bus.stat_stall <= bus.stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_name_feeder.sv
// tb_name_feeder: randomized-table scoreboard bench for name_feeder
module tb_name_feeder;
  import name_feeder_pkg::*;
  localparam int N = 9;
  localparam int L = 8;
  localparam int W = 32;
  localparam int NL = W * L;
  typedef struct { int idx; name_t name; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  name_feeder_if #(.WORD_SIZE(W), .MAX_NAME_LENGTH(L), .NUM_NAMES(N)) ifc ();
  name_feeder #(.WORD_SIZE(W), .MAX_NAME_LENGTH(L), .NUM_NAMES(N)) dut (.clk(clk), .rst(rst), .bus(ifc));
  exp_t q[$];
  exp_t e;
  name_t tbl [N];
  int total = 0;
  int bad = 0;
  logic [NL-1:0] held;
  logic [W-1:0] d;
`ifdef NAME_FEEDER_STATS_EN
  logic [31:0] si, ss;
`endif
  task automatic chk(string nm, logic [NL-1:0] act, logic [NL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(int n);
    for (int i = 0; i < n; i++) q.push_back('{i, tbl[i]});
  endtask
  task automatic wr(int nm, int wd, logic [W-1:0] v);
    ifc.wr_en = 1'b1;
    ifc.wr_name = 4'(nm);
    ifc.wr_word = 3'(wd);
    ifc.wr_data = v;
    tick();
    ifc.wr_en = 1'b0;
  endtask
  task automatic start_run(int cnt, bit lp);
    ifc.cfg_count = 5'(cnt);
    ifc.cfg_loop = lp;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask
  task automatic run_valid(int n, string nm);
    for (int i = 0; i < n; i++) begin
      chk(nm, ifc.out_valid, 1);
      tick();
    end
  endtask
  always @(negedge clk)
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (q.size() == 0) chk("issue_expected", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("out_idx", ifc.out_idx, e.idx);
        chk("out_name", ifc.out_name, e.name);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    ifc.wr_en = 0; ifc.wr_name = 0; ifc.wr_word = 0; ifc.wr_data = 0;
    ifc.cfg_count = 0; ifc.cfg_loop = 0; ifc.start = 0; ifc.stop = 0; ifc.out_ready = 0;
    repeat (3) tick();
    chk("rst_valid", ifc.out_valid, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_wr_err", ifc.wr_err, 0);
    chk("rst_idx", ifc.out_idx, 0);
    chk("rst_name", ifc.out_name, 0);
    rst = 1'b0;
    for (int n = 0; n < N; n++)
      for (int w = 0; w < L; w++) begin
        d = $urandom;
        tbl[n][w] = d;
        wr(n, w, d);
        chk("wr_err_legal", ifc.wr_err, 0);
      end
    ifc.out_ready = 1'b1;
    push(9);
    start_run(9, 0);
    run_valid(9, "full_valid");
    chk("full_done", ifc.done, 1);
    chk("full_valid_after", ifc.out_valid, 0);
    push(3);
    push(3);
    start_run(3, 1);
    for (int i = 0; i < 6; i++) begin
      chk("loop_valid", ifc.out_valid, 1);
      if (i == 5) ifc.stop = 1'b1;
      tick();
    end
    ifc.stop = 1'b0;
    chk("loop_stop_valid", ifc.out_valid, 0);
    chk("loop_stop_done", ifc.done, 0);
    push(9);
    start_run(9, 0);
    tick();
    tick();
    ifc.out_ready = 1'b0;
    held = ifc.out_name;
`ifdef NAME_FEEDER_STATS_EN
    si = ifc.stat_issued;
    ss = ifc.stat_stall;
    chk("stat_issued_pre", si, 2);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("stall_idx", ifc.out_idx, 2);
      chk("stall_name", ifc.out_name, held);
      tick();
    end
`ifdef NAME_FEEDER_STATS_EN
    chk("stall_issued", ifc.stat_issued, si);
    chk("stall_count", ifc.stat_stall, ss + 32'd4);
`endif
    ifc.out_ready = 1'b1;
    run_valid(7, "stall_resume");
    chk("stall_done", ifc.done, 1);
`ifdef NAME_FEEDER_STATS_EN
    chk("stat_issued_total", ifc.stat_issued, 9);
`endif
    start_run(0, 0);
    chk("zero_done", ifc.done, 1);
    chk("zero_valid", ifc.out_valid, 0);
    tick();
    chk("zero_valid2", ifc.out_valid, 0);
    push(9);
    start_run(12, 0);
    run_valid(9, "clamp_valid");
    chk("clamp_done", ifc.done, 1);
    ifc.out_ready = 1'b0;
    push(9);
    start_run(9, 0);
    wr(3, 0, ~tbl[3][0]);
    chk("run_wr_err", ifc.wr_err, 1);
    chk("run_wr_idx", ifc.out_idx, 0);
    tick();
    chk("run_wr_err_clr", ifc.wr_err, 0);
    ifc.out_ready = 1'b1;
    run_valid(9, "run_wr_valid");
    chk("run_wr_done", ifc.done, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("idle_done", ifc.done, 0);
    wr(9, 0, $urandom);
    chk("oob_wr_err", ifc.wr_err, 1);
    tick();
    chk("oob_wr_err_clr", ifc.wr_err, 0);
    d = $urandom;
    tbl[1][2] = d;
    wr(1, 2, d);
    chk("legal_wr_err", ifc.wr_err, 0);
    push(5);
    start_run(9, 0);
    run_valid(4, "stop_valid");
    chk("stop_idx", ifc.out_idx, 4);
    ifc.stop = 1'b1;
    tick();
    ifc.stop = 1'b0;
    chk("stop_idle_valid", ifc.out_valid, 0);
    chk("stop_idle_done", ifc.done, 0);
`ifdef NAME_FEEDER_STATS_EN
    chk("stop_issued", ifc.stat_issued, 5);
`endif
    push(5);
    start_run(9, 0);
    run_valid(5, "rst_run_valid");
    chk("rst_run_idx", ifc.out_idx, 5);
    ifc.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    chk("midrst_valid", ifc.out_valid, 0);
    chk("midrst_done", ifc.done, 0);
    chk("midrst_wr_err", ifc.wr_err, 0);
    chk("midrst_idx", ifc.out_idx, 0);
    chk("midrst_name", ifc.out_name, 0);
`ifdef NAME_FEEDER_STATS_EN
    chk("midrst_issued", ifc.stat_issued, 0);
    chk("midrst_stall", ifc.stat_stall, 0);
`endif
    push(9);
    start_run(9, 0);
    run_valid(9, "intact_valid");
    chk("intact_done", ifc.done, 1);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/name_feeder.md
NAME_FEEDER -- requirements
Module: name_feeder

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, name word width in bits.
REQ-002 SHALL have parameter MAX_NAME_LENGTH, default 8, words per name.
REQ-003 SHALL have parameter NUM_NAMES, default 9, name table depth; legal range 2 or more.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port wr_en, input, 1, table word write strobe.
REQ-007 SHALL have port wr_name, input, clog2(NUM_NAMES), table entry index.
REQ-008 SHALL have port wr_word, input, clog2(MAX_NAME_LENGTH), word index within the entry.
REQ-009 SHALL have port wr_data, input, WORD_SIZE, word to write.
REQ-010 SHALL have port wr_err, output, 1, one-cycle pulse when a write is rejected.
REQ-011 SHALL have port cfg_count, input, clog2(NUM_NAMES)+1, number of names to issue.
REQ-012 SHALL have port cfg_loop, input, 1; 1 = wrap to entry 0 after the last entry, 0 = one-shot.
REQ-013 SHALL have port start, input, 1, begin a run.
REQ-014 SHALL have port stop, input, 1, abort the current run.
REQ-015 SHALL have port out_valid, output, 1, name presented.
REQ-016 SHALL have port out_ready, input, 1, consumer accepts.
REQ-017 SHALL have port out_name, output, WORD_SIZE*MAX_NAME_LENGTH; word j occupies bits [j*WORD_SIZE +: WORD_SIZE].
REQ-018 SHALL have port out_idx, output, clog2(NUM_NAMES), table index of out_name.
REQ-019 SHALL have port done, output, 1, high while in DONE.

Function
REQ-020 SHALL implement states IDLE, RUN and DONE.
REQ-021 SHALL, in IDLE or DONE, latch cfg_count and cfg_loop on start and go to RUN with idx=0; if the latched count is 0, SHALL go directly to DONE without asserting out_valid.
REQ-022 SHALL, in RUN, drive out_valid=1, out_name=table[idx] and out_idx=idx; out_name and out_idx SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 SHALL treat a handshake (out_valid and out_ready both 1) as issuing one name, and SHALL advance idx on the next edge.
REQ-024 SHALL, on a handshake with idx equal to count-1, wrap idx to 0 and stay in RUN if loop is set, otherwise go to DONE.
REQ-025 SHALL clamp a latched count greater than NUM_NAMES to NUM_NAMES.
REQ-026 SHALL, on stop in RUN, go to IDLE on the next edge; a handshake in the same cycle SHALL still complete and be counted.
REQ-027 SHALL ignore start while in RUN.
REQ-028 SHALL ignore stop when not in RUN.
REQ-029 SHALL write the table on wr_en only in IDLE or DONE.
REQ-030 SHALL, on wr_en in RUN, leave the table unchanged and pulse wr_err for one cycle.
REQ-031 SHALL, on wr_en with an out-of-range wr_name or wr_word, discard the write and pulse wr_err.
REQ-032 SHALL make a table write visible to out_name on the first RUN cycle after it.

Reset
REQ-033 SHALL, on rst, enter IDLE and drive out_valid=0, done=0, wr_err=0, out_idx=0 and out_name=0.
REQ-034 SHALL clear the latched count, loop flag and idx on rst.
REQ-035 SHALL preserve table contents across rst.
REQ-036 SHALL give rst priority over start, stop and wr_en, including when asserted mid-run.

Configuration
REQ-037 SHALL, with macro NAME_FEEDER_STATS_EN defined, add output stat_issued (32 bits), counting handshakes.
REQ-038 SHALL, with NAME_FEEDER_STATS_EN defined, add output stat_stall (32 bits), counting cycles with out_valid=1 and out_ready=0.
REQ-039 SHALL saturate both statistics counters at all-ones, clear them on rst and clear them on each accepted start.
REQ-040 SHALL, without NAME_FEEDER_STATS_EN, omit both statistics ports and their counters.

Structure
REQ-041 SHALL place the state enum, the word_t and name_t typedefs, and the default WORD_SIZE and MAX_NAME_LENGTH constants in package name_feeder_pkg.
REQ-042 SHALL hold the table in sub-module name_table: a register file with one write port and one combinational whole-name read port.

Verification
REQ-043 Bench SHALL load 9 names, start with cfg_count=9, cfg_loop=0, out_ready=1 -> indices 0..8 issued on 9 consecutive cycles, then done=1 and out_valid=0.
REQ-044 Bench SHALL run cfg_count=3, cfg_loop=1 -> index sequence 0,1,2,0,1,2 with no bubble at the wrap.
REQ-045 Bench SHALL hold out_ready=0 for 4 cycles on entry 2 -> out_name stable, and stat_issued unchanged while stat_stall increases by 4.
REQ-046 Bench SHALL start with cfg_count=0 -> done=1 with no valid cycle; and with cfg_count=12 -> exactly 9 names issued.
REQ-047 Bench SHALL write during RUN -> wr_err pulses and the entry is unchanged; write to wr_name=9 in IDLE -> wr_err pulses.
REQ-048 Bench SHALL assert stop together with a handshake at idx 4 -> that name counted, IDLE next cycle; rst at idx 5 -> IDLE, outputs 0, table intact.
